block_xfer_ctrl: RTL and testbench

Sequencer for the HuC6280 block-transfer instructions (TII, TDD, TIN, TIA, TAI). It drives the virtual address and read/write strobes into the MMU, moving one byte per read/write pair. It honours MMU_stall (VDC/VCE wait) and global RDY. It sits between the CPU core's instruction decoder and the MMU; the core hands over source, destination, length and mode, then waits on busy/done.

---
 rtl/huc6280_pkg.sv | 38 +++
 rtl/xfer_addr_gen.sv | 53 +++++
 rtl/block_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_block_xfer_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/huc6280_pkg.sv
// Shared types and constants for the HuC6280 block-transfer sequencer.
// Mode and length decode helpers live here so the top stays focused on sequencing.
package huc6280_pkg;

  typedef enum logic [2:0] {
    MODE_TII = 3'd0,
    MODE_TDD = 3'd1,
    MODE_TIN = 3'd2,
    MODE_TIA = 3'd3,
    MODE_TAI = 3'd4
  } xfer_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } xfer_state_t;

  localparam logic [16:0] LEN_FULL = 17'h10000;

  // Undefined opcode encodings fall back to TII behaviour.
  function automatic xfer_mode_t decode_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return MODE_TDD;
      3'd2:    return MODE_TIN;
      3'd3:    return MODE_TIA;
      3'd4:    return MODE_TAI;
      default: return MODE_TII;
    endcase
  endfunction

  function automatic logic [16:0] decode_len(input logic [15:0] raw);
    return (raw == 16'd0) ? LEN_FULL : {1'b0, raw};
  endfunction

endpackage

// File: rtl/xfer_addr_gen.sv
// Source/destination pointer registers and per-mode address generation
// for the block-transfer sequencer.
module xfer_addr_gen
  import huc6280_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_src,
  input  logic [15:0] load_dst,
  input  xfer_mode_t  mode,
  input  logic        alt,
  input  logic        advance,
  output logic [15:0] src_addr,
  output logic [15:0] dst_addr
);

  logic [15:0] sp;
  logic [15:0] dp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= 16'd0;
      dp <= 16'd0;
    end else if (load) begin
      sp <= load_src;
      dp <= load_dst;
    end else if (advance) begin
      // Alternating modes keep their fixed side still; alt supplies the wobble.
      case (mode)
        MODE_TDD: begin
          sp <= sp - 16'd1;
          dp <= dp - 16'd1;
        end
        MODE_TIN: sp <= sp + 16'd1;
        MODE_TIA: sp <= sp + 16'd1;
        MODE_TAI: dp <= dp + 16'd1;
        default: begin
          sp <= sp + 16'd1;
          dp <= dp + 16'd1;
        end
      endcase
    end
  end

  always_comb begin
    src_addr = sp;
    dst_addr = dp;
    if (mode == MODE_TAI) src_addr = sp + {15'd0, alt};
    if (mode == MODE_TIA) dst_addr = dp + {15'd0, alt};
  end

endmodule

// File: rtl/block_xfer_ctrl.sv
// HuC6280 block-transfer sequencer: one byte per read/write pair into the MMU,
// with optional bus-idle gap after each write, honouring MMU_stall and RDY.
module block_xfer_ctrl
  import huc6280_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RDY,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  input  logic        MMU_stall,
  input  logic [7:0]  d_in,
  output logic [15:0] VADDR,
  output logic        RE,
  output logic        WE,
  output logic [7:0]  d_out,
  output logic        busy,
  output logic        done
);

  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  xfer_state_t state, state_next;
  xfer_mode_t  mode_q;
  logic [16:0] cnt;
  logic [7:0]  databuf;
  logic [15:0] last_vaddr;
  logic [2:0]  gap_cnt;
  logic        alt;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic        load;
  logic        read_ok;
  logic        write_ok;

  assign load     = RDY && (state == ST_IDLE) && start;
  assign read_ok  = RDY && (state == ST_READ) && !MMU_stall;
  assign write_ok = RDY && (state == ST_WRITE) && !MMU_stall;

  xfer_addr_gen u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_src (src),
    .load_dst (dst),
    .mode     (mode_q),
    .alt      (alt),
    .advance  (write_ok),
    .src_addr (src_addr),
    .dst_addr (dst_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else if (RDY) state <= state_next;
  end

  // Transfer bookkeeping; everything freezes while RDY is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_TII;
      cnt        <= 17'd0;
      alt        <= 1'b0;
      databuf    <= 8'd0;
      last_vaddr <= 16'd0;
      gap_cnt    <= 3'd0;
    end else begin
      if (load) begin
        mode_q <= decode_mode(mode);
        cnt    <= decode_len(len);
        alt    <= 1'b0;
      end
      if (read_ok) databuf <= d_in;
      if (write_ok) begin
        alt        <= ~alt;
        cnt        <= cnt - 17'd1;
        last_vaddr <= dst_addr;
        gap_cnt    <= 3'd0;
      end
      if (RDY && state == ST_GAP) gap_cnt <= gap_cnt + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    VADDR      = 16'd0;
    RE         = 1'b0;
    WE         = 1'b0;
    d_out      = 8'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_READ;
      end
      ST_READ: begin
        VADDR = src_addr;
        RE    = 1'b1;
        busy  = 1'b1;
        if (!MMU_stall) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        VADDR = dst_addr;
        WE    = 1'b1;
        d_out = databuf;
        busy  = 1'b1;
        if (!MMU_stall) begin
          if (cnt == 17'd1)  state_next = ST_DONE;
          else if (HAS_GAP)  state_next = ST_GAP;
          else               state_next = ST_READ;
        end
      end
      ST_GAP: begin
        VADDR = last_vaddr;
        busy  = 1'b1;
        if (gap_cnt == GAP_LAST) state_next = ST_READ;
      end
      ST_DONE: begin
        VADDR      = last_vaddr;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_xfer_ctrl.sv
// Self-checking bench for block_xfer_ctrl: two instances (no gap / 2-cycle gap)
// compared cycle by cycle against a phase-list model of each transfer.
module tb_block_xfer_ctrl;

  localparam int PH_R = 0;
  localparam int PH_W = 1;
  localparam int PH_G = 2;
  localparam int PH_D = 3;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
  } phase_t;

  logic        clk = 1'b0;
  logic        reset_n, RDY, start, MMU_stall;
  logic [2:0]  mode;
  logic [15:0] src, dst, len;
  logic [15:0] vaddr_n, vaddr_g;
  logic        re_n, re_g, we_n, we_g, busy_n, busy_g, done_n, done_g;
  logic [7:0]  dout_n, dout_g, din_n, din_g;
  logic [7:0]  mem [0:65535];
  int          sel;
  int          checks;
  int          failures;
  phase_t      q[$];

  logic [15:0] s_vaddr;
  logic        s_re, s_we, s_busy, s_done;
  logic [7:0]  s_dout;

  always #5 clk = ~clk;

  // Read data is corrupted while stalled so an early capture shows up.
  assign din_n = MMU_stall ? ~mem[vaddr_n] : mem[vaddr_n];
  assign din_g = MMU_stall ? ~mem[vaddr_g] : mem[vaddr_g];

  assign s_vaddr = (sel == 1) ? vaddr_g : vaddr_n;
  assign s_re    = (sel == 1) ? re_g    : re_n;
  assign s_we    = (sel == 1) ? we_g    : we_n;
  assign s_busy  = (sel == 1) ? busy_g  : busy_n;
  assign s_done  = (sel == 1) ? done_g  : done_n;
  assign s_dout  = (sel == 1) ? dout_g  : dout_n;

  block_xfer_ctrl #(.GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .MMU_stall(MMU_stall), .d_in(din_n),
    .VADDR(vaddr_n), .RE(re_n), .WE(we_n), .d_out(dout_n), .busy(busy_n), .done(done_n)
  );

  block_xfer_ctrl #(.GAP_CYCLES(2)) dut_gap (
    .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .MMU_stall(MMU_stall), .d_in(din_g),
    .VADDR(vaddr_g), .RE(re_g), .WE(we_g), .d_out(dout_g), .busy(busy_g), .done(done_g)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Expected bus phases from closed-form address rules per mode.
  function automatic void buildPhases(input int md, input logic [15:0] s0, input logic [15:0] d0,
                                      input int n, input int g, input int limit);
    int     nb;
    phase_t p;
    logic [15:0] sa, da, iv, av;
    q.delete();
    nb = (n < limit) ? n : limit;
    for (int i = 0; i < nb; i++) begin
      iv = 16'(i);
      av = 16'(i % 2);
      case (md)
        1:       begin sa = s0 - iv; da = d0 - iv; end
        2:       begin sa = s0 + iv; da = d0;      end
        3:       begin sa = s0 + iv; da = d0 + av; end
        4:       begin sa = s0 + av; da = d0 + iv; end
        default: begin sa = s0 + iv; da = d0 + iv; end
      endcase
      p.idx = i; p.kind = PH_R; p.addr = sa; p.data = 8'd0;
      q.push_back(p);
      p.kind = PH_W; p.addr = da; p.data = mem[sa];
      q.push_back(p);
      if (i < n - 1)
        for (int k = 0; k < g; k++) begin
          p.kind = PH_G;
          q.push_back(p);
        end
    end
    if (nb == n) begin
      p.kind = PH_D;
      q.push_back(p);
    end
  endfunction

  task automatic waitIdle();
    int k;
    start = 1'b0; RDY = 1'b1; MMU_stall = 1'b0;
    k = 0;
    @(negedge clk);
    while ((busy_n || done_n || busy_g || done_g) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int which, input int md, input logic [15:0] s0, input logic [15:0] d0,
                               input logic [15:0] l0, input int sched, input int stall_pct, input int rdy_pct,
                               input int abort_at, input int extra_start_at, input int exp_done);
    int     n, j, writes, dut_done, stall_used, rdy_used;
    bit     finished;
    phase_t h;
    waitIdle();
    sel = which;
    n = (l0 == 16'd0) ? 65536 : int'(l0);
    buildPhases(md, s0, d0, n, (which == 1) ? 2 : 0, (abort_at > 0) ? abort_at : n);
    @(posedge clk); #1;
    start = 1'b1; mode = 3'(md); src = s0; dst = d0; len = l0; RDY = 1'b1;
    MMU_stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("idle_busy", 32'(s_busy), 32'd0);
    checkOutput("idle_re", 32'(s_re), 32'd0);
    j = 0; writes = 0; dut_done = -1; stall_used = 0; rdy_used = 0; finished = 1'b0;
    while (!finished && j < 20000) begin
      @(posedge clk); #1;
      j++;
      start = (j == extra_start_at);
      mode = 3'($urandom); src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
      if (sched == 1) begin
        MMU_stall = (q[0].kind == PH_R && q[0].idx == 1 && stall_used < 2);
        if (MMU_stall) stall_used++;
        RDY = !(q[0].kind == PH_W && q[0].idx == 0 && rdy_used < 3);
        if (!RDY) rdy_used++;
      end else begin
        MMU_stall = ($urandom_range(0, 99) < stall_pct);
        RDY = !($urandom_range(0, 99) < rdy_pct);
      end
      @(negedge clk);
      h = q[0];
      checkOutput("re", 32'(s_re), 32'(h.kind == PH_R));
      checkOutput("we", 32'(s_we), 32'(h.kind == PH_W));
      checkOutput("busy", 32'(s_busy), 32'(h.kind != PH_D));
      checkOutput("done", 32'(s_done), 32'(h.kind == PH_D));
      if (h.kind != PH_D) checkOutput("vaddr", 32'(s_vaddr), 32'(h.addr));
      if (h.kind == PH_W) checkOutput("d_out", 32'(s_dout), 32'(h.data));
      if (s_done && dut_done < 0) dut_done = j;
      if (s_we && RDY && !MMU_stall) writes++;
      if (abort_at > 0 && j == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_we", 32'(s_we), 32'd0);
        checkOutput("rst_re", 32'(s_re), 32'd0);
        checkOutput("rst_busy", 32'(s_busy), 32'd0);
        checkOutput("rst_vaddr", 32'(s_vaddr), 32'd0);
        RDY = 1'b1; MMU_stall = 1'b0; start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("rst_no_write", 32'(s_we), 32'd0);
        end
        reset_n = 1'b1;
        return;
      end
      if ((h.kind == PH_R || h.kind == PH_W) ? (RDY && !MMU_stall) : RDY) begin
        void'(q.pop_front());
        if (h.kind == PH_D) finished = 1'b1;
      end
    end
    checkOutput("finished", 32'(finished), 32'd1);
    checkOutput("byte_count", 32'(writes), 32'(n));
    if (exp_done > 0) checkOutput("done_cycle", 32'(dut_done), 32'(exp_done));
    @(posedge clk); #1;
    start = 1'b0; RDY = 1'b1; MMU_stall = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'(s_done), 32'd0);
    checkOutput("post_busy", 32'(s_busy), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; sel = 0;
    reset_n = 1'b0; RDY = 1'b1; start = 1'b0; MMU_stall = 1'b0;
    mode = 3'd0; src = 16'd0; dst = 16'd0; len = 16'd0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #12;
    checkOutput("reset_vaddr", 32'({vaddr_n, vaddr_g}), 32'd0);
    checkOutput("reset_strobes", 32'({re_n, we_n, re_g, we_g}), 32'd0);
    checkOutput("reset_busy_done", 32'({busy_n, done_n, busy_g, done_g}), 32'd0);
    checkOutput("reset_dout", 32'({dout_n, dout_g}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed transfers");
    applyStimulus(0, 0, 16'h2000, 16'h3000, 16'd3, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 1, 16'h0001, 16'h0000, 16'd3, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 3, 16'h5000, 16'h0402, 16'd4, 0, 0, 0, 0, 0, 9);
    applyStimulus(0, 4, 16'h0404, 16'h6000, 16'd3, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 16'h2000, 16'h3000, 16'd3, 1, 0, 0, 0, 0, 12);
    applyStimulus(0, 6, 16'hFFFF, 16'h7000, 16'd1, 0, 0, 0, 0, 0, 3);

    $display("[TB] len=0 TIN with ignored restart, aborted by reset");
    applyStimulus(0, 2, 16'h8000, 16'h1FFF, 16'd0, 0, 0, 0, 400, 10, 0);

    $display("[TB] reset during write with 2-cycle gaps, then rerun");
    applyStimulus(1, 0, 16'h0100, 16'h0200, 16'd4, 0, 0, 0, 2, 0, 0);
    applyStimulus(1, 0, 16'h0100, 16'h0200, 16'd4, 0, 0, 0, 0, 0, 15);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 14; t++) begin
      logic [15:0] rs, rd;
      rs = 16'($urandom);
      rd = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rs = 16'hFFF8 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rd = 16'($urandom_range(0, 7));
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), rs, rd,
                    16'($urandom_range(1, 20)), 0, 30, 25, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
